scan_seq_ctrl: RTL and testbench
================================

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4: width of shift-length and bit-index fields.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request one capture/shift/update sequence.
REQ-005 SHALL have port shift_len, input, NUM_CNT_BITS bits: number of shift cycles; sampled only when start is accepted.
REQ-006 SHALL have port pause, input, 1 bit: stalls the SHIFT state.
REQ-007 SHALL have port abort, input, 1 bit: terminates an active sequence without update.
REQ-008 SHALL have port capture, output, 1 bit: one-cycle capture strobe.
REQ-009 SHALL have port shift_en, output, 1 bit: high in each active shift cycle.
REQ-010 SHALL have port last_bit, output, 1 bit: high with shift_en in the final shift cycle.
REQ-011 SHALL have port update, output, 1 bit: one-cycle update strobe.
REQ-012 SHALL have port bit_idx, output, NUM_CNT_BITS bits: zero-based index of the current shift bit.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port aborted, output, 1 bit: one-cycle pulse after an abort.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, SHIFT, UPDATE, DONE; all strobe outputs are decoded from registered state (Moore).
REQ-018 In IDLE, start=1 with shift_len!=0 SHALL latch shift_len into len_q, clear bit_idx to 0, and go to CAPTURE.
REQ-019 In IDLE, start=1 with shift_len==0 SHALL stay in IDLE and pulse err in the next cycle.
REQ-020 start outside IDLE SHALL be ignored; no err, and len_q is unchanged.
REQ-021 CAPTURE SHALL last exactly one cycle with capture=1, then go to SHIFT.
REQ-022 In SHIFT with pause=0: shift_en=1; if bit_idx==len_q-1, assert last_bit and go to UPDATE; otherwise increment bit_idx by 1.
REQ-023 In SHIFT with pause=1: shift_en=0, last_bit=0, bit_idx holds, state holds.
REQ-024 UPDATE SHALL last one cycle with update=1, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 Latency: start accepted at edge N gives capture in cycle N+1, shift cycles N+2..N+1+len (no pause), update in N+2+len, done in N+3+len; each pause cycle adds one cycle.
REQ-026 abort=1 in CAPTURE or SHIFT SHALL go to IDLE at the next edge, suppress update and done, and pulse aborted for one cycle.
REQ-027 abort has priority over pause and over the last-bit transition; abort in UPDATE, DONE or IDLE SHALL be ignored.
REQ-028 Maximum shift_len (2^NUM_CNT_BITS-1) SHALL produce exactly that many shift cycles; bit_idx SHALL never wrap within a sequence.
REQ-029 bit_idx SHALL hold its last value in UPDATE, DONE and IDLE until the next accepted start.
REQ-030 shift_len changes after acceptance SHALL NOT affect the active sequence.

Reset
REQ-031 n_rst=0 at a rising edge SHALL force IDLE, len_q=0 and bit_idx=0; all outputs read 0 from the next cycle.
REQ-032 Reset mid-sequence SHALL discard the sequence with no update, done or aborted pulse; n_rst SHALL override start, abort and pause.
REQ-033 After reset release, the first start SHALL be accepted at the first edge with n_rst=1.

Verification
REQ-034 NUM_CNT_BITS=4, shift_len=3, start pulse: capture 1 cycle; shift_en 3 cycles with bit_idx 0,1,2 and last_bit on idx 2; update 1 cycle; done 1 cycle; busy high for 6 cycles.
REQ-035 shift_len=5, pause high for 2 cycles at bit_idx=2: bit_idx holds at 2 with shift_en=0; sequence ends 2 cycles later than unpaused; 5 shift_en cycles total.
REQ-036 shift_len=4, abort at bit_idx=1: IDLE next cycle; aborted pulses once; update and done never assert.
REQ-037 start with shift_len=0: err for 1 cycle, busy stays 0; then start with shift_len=15: 15 shift cycles, bit_idx reaches 14 with no wrap.
REQ-038 n_rst=0 during SHIFT at bit_idx=3: all outputs 0 next cycle and no done; restart after release completes normally.
REQ-039 Second start and shift_len change during SHIFT: ignored; original length is completed.

Source files
------------

// File: rtl/scan_seq_ctrl_if.sv
// Control/status bundle between a scan sequencer and its requester.
// start is a request: it is taken only in IDLE; busy=0 shows when it will be taken.
interface scan_seq_ctrl_if #(
   parameter int NUM_CNT_BITS = 4
);
   logic                    start;
   logic [NUM_CNT_BITS-1:0] shift_len;
   logic                    pause;
   logic                    abort;
   logic                    capture;
   logic                    shift_en;
   logic                    last_bit;
   logic                    update;
   logic [NUM_CNT_BITS-1:0] bit_idx;
   logic                    busy;
   logic                    done;
   logic                    aborted;
   logic                    err;
   logic [2:0]              dbg_state;

   modport master (
      output start, shift_len, pause, abort,
      input  capture, shift_en, last_bit, update, bit_idx, busy, done, aborted, err, dbg_state
   );

   modport slave (
      input  start, shift_len, pause, abort,
      output capture, shift_en, last_bit, update, bit_idx, busy, done, aborted, err, dbg_state
   );
endinterface

// File: rtl/scan_seq_ctrl.sv
// Capture/shift/update sequencer: one capture strobe, len_q shift cycles
// (stallable by pause), one update strobe, then a done pulse.
module scan_seq_ctrl #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic clk,
   input  logic n_rst,
   scan_seq_ctrl_if.slave bus
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CAPTURE = 3'd1;
   localparam logic [2:0] ST_SHIFT   = 3'd2;
   localparam logic [2:0] ST_UPDATE  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

   logic [2:0]              state_q;
   logic [NUM_CNT_BITS-1:0] len_q;
   logic [NUM_CNT_BITS-1:0] idx_q;
   logic [NUM_CNT_BITS-1:0] last_idx;
   logic                    err_q;
   logic                    aborted_q;

   // len_q is never zero while shifting, so this cannot underflow there.
   assign last_idx = len_q - ONE;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.shift_len != '0) begin
                     len_q   <= bus.shift_len;
                     idx_q   <= '0;
                     state_q <= ST_CAPTURE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               if (bus.abort) begin
                  state_q   <= ST_IDLE;
                  aborted_q <= 1'b1;
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // abort outranks both pause and the final-bit exit.
               if (bus.abort) begin
                  state_q   <= ST_IDLE;
                  aborted_q <= 1'b1;
               end else if (!bus.pause) begin
                  if (idx_q == last_idx) state_q <= ST_UPDATE;
                  else                   idx_q   <= idx_q + ONE;
               end
            end
            ST_UPDATE: state_q <= ST_DONE;
            ST_DONE:   state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.capture   = (state_q == ST_CAPTURE);
   assign bus.shift_en  = (state_q == ST_SHIFT) && !bus.pause;
   assign bus.last_bit  = bus.shift_en && (idx_q == last_idx);
   assign bus.update    = (state_q == ST_UPDATE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.bit_idx   = idx_q;
   assign bus.err       = err_q;
   assign bus.aborted   = aborted_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: each step drives inputs after a rising edge
// and checks the full output vector at the following falling edge.
module tb_scan_seq_ctrl;
   logic clk;
   logic n_rst;
   int   compared;
   int   mismatched;

   scan_seq_ctrl_if #(.NUM_CNT_BITS(4)) bus ();

   scan_seq_ctrl #(.NUM_CNT_BITS(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: {capture, shift_en, last_bit, update, busy, done, aborted, err}
   localparam logic [7:0] V_IDLE = 8'b0000_0000;
   localparam logic [7:0] V_CAP  = 8'b1000_1000;
   localparam logic [7:0] V_SH   = 8'b0100_1000;
   localparam logic [7:0] V_LAST = 8'b0110_1000;
   localparam logic [7:0] V_PAUS = 8'b0000_1000;
   localparam logic [7:0] V_UPD  = 8'b0001_1000;
   localparam logic [7:0] V_DONE = 8'b0000_1100;
   localparam logic [7:0] V_ABT  = 8'b0000_0010;
   localparam logic [7:0] V_ERR  = 8'b0000_0001;

   task automatic cyc(input string tag, input logic rst_n, input logic st,
                      input logic [3:0] len, input logic pa, input logic ab,
                      input logic [7:0] exp_v, input logic [3:0] exp_idx);
      logic [11:0] obs;
      logic [11:0] exp;
      @(posedge clk);
      #1;
      n_rst         = rst_n;
      bus.start     = st;
      bus.shift_len = len;
      bus.pause     = pa;
      bus.abort     = ab;
      @(negedge clk);
      obs = {bus.capture, bus.shift_en, bus.last_bit, bus.update, bus.busy,
             bus.done, bus.aborted, bus.err, bus.bit_idx};
      exp = {exp_v, exp_idx};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      n_rst = 1'b0;
      bus.start = 1'b0;
      bus.shift_len = 4'd0;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      compared = 0;
      mismatched = 0;

      // Reset, then start on the very first released edge: len 3
      cyc("rst0",   1'b0, 1'b1, 4'd3, 1'b1, 1'b1, V_IDLE, 4'd0);
      cyc("rst1",   1'b1, 1'b1, 4'd3, 1'b0, 1'b0, V_IDLE, 4'd0);
      cyc("l3_cap", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("l3_s0",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("l3_s1",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd1);
      cyc("l3_s2",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_LAST, 4'd2);
      cyc("l3_upd", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_UPD,  4'd2);
      cyc("l3_done",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_DONE, 4'd2);
      cyc("l3_idle",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd2);

      // len 5 with a two-cycle pause at bit 2
      cyc("p5_req", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, V_IDLE, 4'd2);
      cyc("p5_cap", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("p5_s0",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("p5_s1",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd1);
      cyc("p5_pa0", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, V_PAUS, 4'd2);
      cyc("p5_pa1", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, V_PAUS, 4'd2);
      cyc("p5_s2",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd2);
      cyc("p5_s3",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd3);
      cyc("p5_s4",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_LAST, 4'd4);
      cyc("p5_upd", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_UPD,  4'd4);
      cyc("p5_done",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_DONE, 4'd4);
      cyc("p5_idle",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd4);

      // len 4 aborted at bit 1 (abort wins over pause too)
      cyc("a4_req", 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, V_IDLE, 4'd4);
      cyc("a4_cap", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("a4_s0",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("a4_ab",  1'b1, 1'b0, 4'd0, 1'b1, 1'b1, V_PAUS, 4'd1);
      cyc("a4_abtd",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_ABT,  4'd1);
      cyc("a4_idl0",1'b1, 1'b0, 4'd0, 1'b0, 1'b1, V_IDLE, 4'd1);
      cyc("a4_idl1",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd1);

      // zero length rejected, then the maximum length of 15
      cyc("z_req",  1'b1, 1'b1, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd1);
      cyc("z_err",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_ERR,  4'd1);
      cyc("z_idle", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd1);
      cyc("m_req",  1'b1, 1'b1, 4'd15, 1'b0, 1'b0, V_IDLE, 4'd1);
      cyc("m_cap",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      for (int i = 0; i < 14; i++)
         cyc($sformatf("m_s%0d", i), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH, 4'(i));
      cyc("m_s14",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_LAST, 4'd14);
      cyc("m_upd",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_UPD,  4'd14);
      cyc("m_done", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_DONE, 4'd14);
      cyc("m_idle", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd14);

      // reset at bit 3 of a len 6 run overrides start/abort; restart len 2
      cyc("r6_req", 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, V_IDLE, 4'd14);
      cyc("r6_cap", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("r6_s0",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("r6_s1",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd1);
      cyc("r6_s2",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd2);
      cyc("r6_rst", 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, V_SH,   4'd3);
      cyc("r6_zero",1'b1, 1'b1, 4'd2, 1'b0, 1'b0, V_IDLE, 4'd0);
      cyc("r2_cap", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("r2_s0",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("r2_s1",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_LAST, 4'd1);
      cyc("r2_upd", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_UPD,  4'd1);
      cyc("r2_done",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_DONE, 4'd1);
      cyc("r2_idle",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd1);

      // second start with new length mid-shift is ignored; abort in UPDATE ignored
      cyc("i3_req", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, V_IDLE, 4'd1);
      cyc("i3_cap", 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, V_CAP,  4'd0);
      cyc("i3_s0",  1'b1, 1'b1, 4'd7, 1'b0, 1'b0, V_SH,   4'd0);
      cyc("i3_s1",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_SH,   4'd1);
      cyc("i3_s2",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_LAST, 4'd2);
      cyc("i3_upd", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, V_UPD,  4'd2);
      cyc("i3_done",1'b1, 1'b0, 4'd0, 1'b0, 1'b1, V_DONE, 4'd2);
      cyc("i3_idle",1'b1, 1'b0, 4'd0, 1'b0, 1'b0, V_IDLE, 4'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
